// File: rtl/win_scanner.sv
// Sequential win/draw detector: snapshots a board on start and tests one line per
// clock (rows, columns, main diagonal, anti-diagonal), reporting via busy/done.
module win_scanner #(
  parameter int N      = 5,
  parameter int CELL_W = 3,
  parameter int LINE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CELL_W-1:0]     player_id,
  input  logic [N*N*CELL_W-1:0] board_flat,
  output logic                  busy,
  output logic                  done,
  output logic                  win,
  output logic                  draw,
  output logic [LINE_W-1:0]     win_line
);

  localparam int BOARD_W = N * N * CELL_W;
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(2 * N + 1);

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

  state_t               state_q, state_d;
  logic [BOARD_W-1:0]   board_q, board_d;
  logic [CELL_W-1:0]    pid_q, pid_d;
  logic [LINE_W-1:0]    line_idx_q, line_idx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 win_q, win_d;
  logic                 draw_q, draw_d;
  logic [LINE_W-1:0]    win_line_q, win_line_d;

  // Line idx: rows 0..N-1, columns N..2N-1, main diagonal 2N, anti-diagonal 2N+1.
  function automatic logic line_full(input logic [BOARD_W-1:0] brd,
                                     input logic [CELL_W-1:0]  pid,
                                     input logic [LINE_W-1:0]  idx);
    int   li, r, c;
    logic full;
    li   = int'(idx);
    full = (pid != '0);
    r    = 0;
    c    = 0;
    for (int i = 0; i < N; i++) begin
      if (li < N) begin
        r = li;
        c = i;
      end else if (li < 2 * N) begin
        r = i;
        c = li - N;
      end else if (li == 2 * N) begin
        r = i;
        c = i;
      end else begin
        r = i;
        c = N - 1 - i;
      end
      if (brd[CELL_W*(N*r+c) +: CELL_W] != pid) full = 1'b0;
    end
    return full;
  endfunction

  function automatic logic has_empty(input logic [BOARD_W-1:0] brd);
    logic empty;
    empty = 1'b0;
    for (int i = 0; i < N * N; i++) begin
      if (brd[CELL_W*i +: CELL_W] == '0) empty = 1'b1;
    end
    return empty;
  endfunction

  always_comb begin
    state_d    = state_q;
    board_d    = board_q;
    pid_d      = pid_q;
    line_idx_d = line_idx_q;
    win_d      = win_q;
    draw_d     = draw_q;
    win_line_d = win_line_q;
    // busy lags the state by one cycle so it rises one cycle after acceptance
    // and falls exactly when done is raised.
    busy_d     = (state_q == SCAN);
    done_d     = (state_q == REPORT);
    case (state_q)
      IDLE: begin
        if (start) begin
          board_d    = board_flat;
          pid_d      = player_id;
          line_idx_d = '0;
          win_d      = 1'b0;
          draw_d     = 1'b0;
          win_line_d = '0;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        if (line_full(board_q, pid_q, line_idx_q)) begin
          win_d      = 1'b1;
          win_line_d = line_idx_q;
          state_d    = REPORT;
        end else if (line_idx_q == LAST_LINE) begin
          win_d   = 1'b0;
          draw_d  = !has_empty(board_q);
          state_d = REPORT;
        end else begin
          line_idx_d = line_idx_q + 1'b1;
        end
      end
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      board_q    <= '0;
      pid_q      <= '0;
      line_idx_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      win_q      <= 1'b0;
      draw_q     <= 1'b0;
      win_line_q <= '0;
    end else begin
      state_q    <= state_d;
      board_q    <= board_d;
      pid_q      <= pid_d;
      line_idx_q <= line_idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      win_q      <= win_d;
      draw_q     <= draw_d;
      win_line_q <= win_line_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign win      = win_q;
  assign draw     = draw_q;
  assign win_line = win_line_q;

endmodule

// File: tb/tb_win_scanner.sv
// Scoreboard bench for win_scanner: stimulus pushes expected results, a monitor
// pops and compares them whenever done is seen.
module tb_win_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  player_id;
  logic [74:0] board_flat;
  logic        busy, done, win, draw;
  logic [3:0]  win_line;

  win_scanner #(.N(5), .CELL_W(3), .LINE_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .player_id(player_id),
    .board_flat(board_flat), .busy(busy), .done(done), .win(win),
    .draw(draw), .win_line(win_line)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       win;
    logic       draw;
    logic [3:0] line;
    int         due;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse must correspond to a queued expectation.
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("win", int'(win), int'(e.win));
        check("draw", int'(draw), int'(e.draw));
        check("win_line", int'(win_line), int'(e.line));
        check("done_cycle", cyc, e.due);
        check("busy_at_done", int'(busy), 0);
      end
    end
  end

  function automatic logic [74:0] put(input logic [74:0] b, input int r, input int c,
                                      input logic [2:0] v);
    b[3*(5*r+c) +: 3] = v;
    return b;
  endfunction

  // Drives a one-cycle start; returns #1 after the accepting edge.
  task automatic issue(input logic [74:0] b, input logic [2:0] p, input bit push,
                       input logic w, input logic d, input logic [3:0] l, input int lat);
    exp_t e;
    @(negedge clk);
    board_flat = b;
    player_id  = p;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) begin
      e.win  = w;
      e.draw = d;
      e.line = l;
      e.due  = cyc + lat;
      q.push_back(e);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      check("done_timeout", q.size(), 0);
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_win"}, int'(win), 0);
    check({tag, "_draw"}, int'(draw), 0);
    check({tag, "_line"}, int'(win_line), 0);
  endtask

  logic [74:0] b_row, b_anti, b_draw, b_col, b_nowin;
  int nbusy;

  initial begin
    rst = 1'b1; start = 1'b0; player_id = '0; board_flat = '0;

    b_row = '0;
    for (int c = 0; c < 5; c++) b_row = put(b_row, 2, c, 3'd1);
    b_anti = '0;
    for (int r = 0; r < 5; r++) b_anti = put(b_anti, r, 4 - r, 3'd2);
    b_draw = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        b_draw = put(b_draw, r, c, ((r + c) % 2 == 0) ? 3'd1 : 3'd2);
    b_draw = put(b_draw, 2, 2, 3'd2);
    b_col = '0;
    for (int r = 0; r < 5; r++) b_col = put(b_col, r, 0, 3'd1);
    b_nowin = put('0, 1, 1, 3'd1);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_all_zero("reset");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_all_zero("idle");
    end

    // Row 2 win: done 4 edges after acceptance, busy for 3 cycles
    issue(b_row, 3'd1, 1'b1, 1'b1, 1'b0, 4'd2, 4);
    check("busy_after_accept", int'(busy), 0);
    nbusy = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy) nbusy++;
    end
    check("row_busy_cycles", nbusy, 3);
    drain();

    issue(b_anti, 3'd2, 1'b1, 1'b1, 1'b0, 4'd11, 13);
    drain();
    issue(b_anti, 3'd1, 1'b1, 1'b0, 1'b0, 4'd0, 13);
    drain();

    issue(b_draw, 3'd1, 1'b1, 1'b0, 1'b1, 4'd0, 13);
    drain();
    issue(put(b_draw, 0, 1, 3'd0), 3'd1, 1'b1, 1'b0, 1'b0, 4'd0, 13);
    drain();
    issue(b_draw, 3'd0, 1'b1, 1'b0, 1'b1, 4'd0, 13);
    drain();

    // Column 0 win, then clobber inputs and re-pulse start mid-scan
    issue(b_col, 3'd1, 1'b1, 1'b1, 1'b0, 4'd5, 7);
    board_flat = '0;
    player_id  = 3'd0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (10) @(negedge clk);

    // Reset at edge T+5 aborts the scan
    issue(b_nowin, 3'd1, 1'b0, 1'b0, 1'b0, 4'd0, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all_zero("midreset");
    @(posedge clk);
    #1;
    check_all_zero("after_reset");
    repeat (20) @(negedge clk);

    issue(b_row, 3'd1, 1'b1, 1'b1, 1'b0, 4'd2, 4);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/win_scanner.md
Name: win_scanner

Overview:
- Sequential win/draw detector that consumes the board state produced by the game manager and returns the result that drives curPlayerWon and lastWinner.
- On a start pulse, it snapshots the board and the player id.
- It then evaluates one line per clock: rows, then columns, then the two diagonals.
- It reports win, draw and the index of the winning line through a start/busy/done handshake.

Parameters:
- N, 5, board dimension (N x N); line count is 2N+2.
- CELL_W, 3, bits per cell; value 0 means empty, any non-zero value is a player id.
- LINE_W, 4, width of win_line; must satisfy 2^LINE_W >= 2N+2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to scan; honoured only when busy=0.
- player_id  input  CELL_W  player whose win is checked; sampled with start.
- board_flat  input  N*N*CELL_W  board, cell(r,c) at bits [CELL_W*(N*r+c) +: CELL_W]; sampled with start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  single-cycle pulse when the result is valid.
- win  output  1  player_id owns a complete line.
- draw  output  1  no empty cell and win=0.
- win_line  output  LINE_W  index of the first matching line; valid when win=1, else 0.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE.
  - busy, done, win, draw and win_line all go to 0.
  - Snapshot registers and the line counter are cleared.
  - Reset has priority over every other event.
- States: IDLE, SCAN, REPORT.
- IDLE:
  - If start=1 at edge T, capture board_flat into the snapshot and player_id into pid_q.
  - Clear win, draw and win_line; set line_idx=0; go to SCAN; busy=1 from T+1.
- SCAN (one line per cycle):
  - Line index map: 0..N-1 are rows r; N..2N-1 are columns c; 2N is the main diagonal (r==c); 2N+1 is the anti-diagonal (r+c==N-1).
  - A line matches when all N snapshot cells equal pid_q and pid_q != 0.
  - On a match at line_idx=k: latch win=1 and win_line=k, then go to REPORT.
  - Early exit: the first match wins and later lines are not examined.
  - On no match with line_idx=2N+1: latch win=0 and draw = (no snapshot cell == 0), then go to REPORT.
  - Otherwise line_idx increments by 1.
- REPORT:
  - Assert done=1 for exactly one cycle, deassert busy, return to IDLE.
- Latency, for start accepted at edge T:
  - Match on line k: done is high in the cycle after edge T+k+2.
  - Full scan without a match: done is high after edge T+2N+3, which is T+13 for N=5.
- win, draw and win_line hold their values after done until the next accepted start.
- start while busy=1, or during the REPORT cycle, is ignored. No queueing: the request is lost.
- Changes to board_flat or player_id after capture do not affect an in-progress scan.
- player_id=0 never matches. The full scan runs, win=0, and draw is evaluated normally.
- win and draw are never both 1. A full board with a winning line reports win=1, draw=0.
- rst during SCAN or REPORT aborts the scan with no done pulse and all outputs at 0.
- line_idx never exceeds 2N+1, so it does not wrap.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then rst=0 with start=0 for 20 cycles -> busy=0, done=0, win=0, draw=0, win_line=0 throughout.
- Row win: row 2 all =1, rest empty, player_id=1, start at T -> done after edge T+4, win=1, win_line=2, draw=0, busy high for 3 cycles.
- Anti-diagonal win: cells (0,4),(1,3),(2,2),(3,1),(4,0) =2, player_id=2 -> done after T+13 with win=1, win_line=11. A second start with player_id=1 -> win=0, win_line=0, draw=0.
- Draw: full board alternating 1/2 with no complete line, player_id=1 -> done after T+13, win=0, draw=1. The same board with one cell set to 0 -> draw=0.
- Snapshot and ignore: start with column 0 =1, then zero board_flat and pulse start again mid-scan -> a single done pulse, win=1, win_line=5; busy drops only once.
- Reset mid-scan: start on a board with no win, assert rst at T+5 -> no done pulse ever; all outputs 0 at T+6; a subsequent start works normally.
